fpu_norm_round: RTL
===================

// Module: fpu_norm_round
// PURPOSE
//  Normalization/rounding stage placed directly downstream of the FP adder's pre-normalized result.
//  Consumes sign, 10b signed biased exponent and 48b pre-normalized mantissa (MSB carry at [47], hidden bit at [46]).
//  Produces a packed IEEE-754 single and exception flags.
//  2-stage pipeline with valid/ready backpressure; denormal results are flushed to zero.
// PARAMETERS
//  C_EXP_PRENORM  10  width of signed pre-normalized exponent
//  C_MANT_PRENORM 48  width of pre-normalized mantissa
//  C_EXP          8   result exponent width (bias 127)
//  C_MANT         23  result fraction width
// PORTS
//  Clk_CI           in   1   clock
//  Rst_RBI          in   1   reset, asynchronous, active-low
//  Flush_SI         in   1   synchronous clear of both pipeline stages
//  In_valid_SI      in   1   input operand valid
//  In_ready_SO      out  1   stage can accept input
//  Sign_prenorm_DI  in   1   result sign from adder
//  Exp_prenorm_DI   in   10  signed biased exponent
//  Mant_prenorm_DI  in   48  mantissa, binary point between [46] and [45]
//  RM_SI            in   2   rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
//  Out_valid_SO     out  1   result valid
//  Out_ready_SI     in   1   downstream accepts result
//  Result_DO        out  32  packed single {sign, exp[7:0], frac[22:0]}
//  OF_SO / UF_SO / NX_SO  out 1 each  overflow / underflow / inexact, qualified by Out_valid_SO
// BEHAVIOUR
//  Reset (async): both stage valids=0; Out_valid_SO=0, Result_DO=0, flags=0. Reset mid-operation discards in-flight data.
//  Handshake: a transfer occurs on a cycle with valid&ready. Stage N loads when it is empty or stage N+1 loads/drains.
//   In_ready_SO = ~v1 | (~v2 | Out_ready_SI). Outputs hold stable while Out_valid_SO & ~Out_ready_SI.
//  Latency: 2 cycles, input accept to Out_valid_SO; full throughput of 1 per cycle with no bubbles when ready.
//  Flush_SI: clears v1 and v2 on the next edge; input presented in the same cycle is dropped; priority over load.
//  Stage 1, normalize (registered together with sign and RM):
//   Mant[47]=1 -> shift right 1, E=Exp+1, sticky |= Mant[0].
//   Otherwise L = lzc(Mant[46:0]); shift left by L; E = Exp-L.
//   Mant==0 -> zero flag; sign = Sign_prenorm_DI (upstream resolves the sign of an exact zero).
//  Stage 2, round: kept significand = N[46:23] (24b), G = N[22], S = |N[21:0] | sticky.
//   RNE up = G&(S|N[23]); RTZ up = 0; RDN up = (G|S)&sign; RUP up = (G|S)&~sign.
//   24b increment carry-out -> significand 1.0, E+1. NX = G|S.
//   E>=255 after rounding -> OF=1, NX=1. Result = inf for RNE, RUP&+, RDN&-; else +/-0x7F7FFFFF (max finite).
//   E<=0 -> flush to signed zero; UF=1; NX=1 if significand nonzero. Exact zero -> all flags 0.
//   Arithmetic: E held as 11b signed internally; comparisons are signed; Exp_prenorm_DI may be negative.
// STRUCTURE
//  Shared package fpu_pkg: rounding-mode typedef enum {RNE, RTZ, RDN, RUP}, C_EXP_BIAS=127,
//   C_EXP_INF=8'hFF, C_MAX_FINITE=31'h7F7FFFFF, stage-1 payload struct.
//  One sub-module: fpu_lzc_47, combinational 47b leading-zero counter (6b count, all-zero flag).
//  No FSM beyond per-stage valid bits; pipeline control in this module.
// TESTING
//  Mant=48'h8000_0000_0000, Exp=127, +, RNE -> 0x40000000 two cycles later, flags 000.
//  Mant=48'h7FFF_FFC0_0000, Exp=127, RNE -> 0x40000000, NX=1; same input with RTZ -> 0x3FFFFFFF, NX=1.
//  Mant=48'h8000_0000_0000, Exp=254: RNE -> 0x7F800000, OF=1, NX=1; RTZ -> 0x7F7FFFFF, OF=1.
//  Mant=48'h2000_0000_0000, Exp=1 -> 0x00000000, UF=1, NX=1; Mant=0, sign=1 -> 0x80000000, flags 000.
//  4 back-to-back inputs with Out_ready_SI low for 3 cycles -> In_ready_SO low once both stages full;
//   all 4 results in order, no loss or duplication.
//  Rst_RBI asserted and Flush_SI pulsed with both stages full -> Out_valid_SO=0 next cycle, no stale result emitted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP normalize/round datapath.
package fpu_pkg;

    localparam int unsigned C_EXP_PRENORM  = 10;
    localparam int unsigned C_MANT_PRENORM = 48;
    localparam int unsigned C_EXP          = 8;
    localparam int unsigned C_MANT         = 23;

    localparam int unsigned C_EXP_BIAS   = 127;
    localparam logic [7:0]  C_EXP_INF    = 8'hFF;
    localparam logic [30:0] C_MAX_FINITE = 31'h7F7FFFFF;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } rm_e;

    // Normalized operand: hidden bit at mant[46], 11b signed biased exponent.
    typedef struct packed {
        logic               sign;
        logic               zero;
        logic signed [10:0] exp;
        logic [46:0]        mant;
        logic               sticky;
        rm_e                rm;
    } stage1_t;

endpackage

// File: rtl/fpu_lzc_47.sv
// Combinational 47-bit leading-zero counter with all-zero flag.
module fpu_lzc_47 (
    input  logic [46:0] data_i,
    output logic [5:0]  cnt_o,
    output logic        zero_o
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        cnt_o = 6'd47;
        for (int i = 0; i < 47; i++) begin
            if (data_i[i]) begin
                cnt_o = 6'(46 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fpu_norm_round.sv
// Two-stage normalize/round pipeline producing an IEEE-754 single from the adder's
// pre-normalized result; denormals flush to zero.
module fpu_norm_round
    import fpu_pkg::*;
(
    input  logic                      Clk_CI,
    input  logic                      Rst_RBI,
    input  logic                      Flush_SI,
    input  logic                      In_valid_SI,
    output logic                      In_ready_SO,
    input  logic                      Sign_prenorm_DI,
    input  logic [C_EXP_PRENORM-1:0]  Exp_prenorm_DI,
    input  logic [C_MANT_PRENORM-1:0] Mant_prenorm_DI,
    input  logic [1:0]                RM_SI,
    output logic                      Out_valid_SO,
    input  logic                      Out_ready_SI,
    output logic [31:0]               Result_DO,
    output logic                      OF_SO,
    output logic                      UF_SO,
    output logic                      NX_SO
);

    logic v1_q, v2_q;
    logic s1_ready, s2_ready, s1_load, s2_load;

    stage1_t s1_d, s1_q;

    logic [5:0]         lzc_cnt;
    logic               lzc_zero;
    logic signed [10:0] exp_ext;

    logic               guard, sticky, inexact, round_up, carry, to_inf;
    logic [C_MANT-1:0]  frac;
    logic signed [10:0] e_rnd;

    logic [31:0] res_d, res_q;
    logic        of_d, uf_d, nx_d, of_q, uf_q, nx_q;

    assign s2_ready    = ~v2_q | Out_ready_SI;
    assign s1_ready    = ~v1_q | s2_ready;
    assign s1_load     = s1_ready & In_valid_SI & ~Flush_SI;
    assign s2_load     = s2_ready & v1_q & ~Flush_SI;
    assign In_ready_SO = s1_ready;

    // Stage 1: normalize so the leading one sits at bit 46.
    fpu_lzc_47 u_lzc (
        .data_i (Mant_prenorm_DI[46:0]),
        .cnt_o  (lzc_cnt),
        .zero_o (lzc_zero)
    );

    assign exp_ext = {Exp_prenorm_DI[C_EXP_PRENORM-1], Exp_prenorm_DI};

    always_comb begin
        s1_d.sign = Sign_prenorm_DI;
        s1_d.rm   = rm_e'(RM_SI);
        s1_d.zero = ~Mant_prenorm_DI[47] & lzc_zero;
        if (Mant_prenorm_DI[47]) begin
            s1_d.mant   = Mant_prenorm_DI[47:1];
            s1_d.exp    = exp_ext + 11'sd1;
            s1_d.sticky = Mant_prenorm_DI[0];
        end else begin
            s1_d.mant   = Mant_prenorm_DI[46:0] << lzc_cnt;
            s1_d.exp    = exp_ext - $signed({5'b0, lzc_cnt});
            s1_d.sticky = 1'b0;
        end
    end

    // Stage 2: round the 24b significand and classify the result.
    assign guard   = s1_q.mant[22];
    assign sticky  = |s1_q.mant[21:0] | s1_q.sticky;
    assign inexact = guard | sticky;

    always_comb begin
        round_up = 1'b0;
        to_inf   = 1'b0;
        unique case (s1_q.rm)
            RNE: begin
                round_up = guard & (sticky | s1_q.mant[23]);
                to_inf   = 1'b1;
            end
            RTZ: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
            RDN: begin
                round_up = inexact & s1_q.sign;
                to_inf   = s1_q.sign;
            end
            RUP: begin
                round_up = inexact & ~s1_q.sign;
                to_inf   = ~s1_q.sign;
            end
            default: ;
        endcase
    end

    // An all-ones significand wraps the fraction to zero and bumps the exponent.
    assign carry = round_up & (&s1_q.mant[46:23]);
    assign frac  = s1_q.mant[45:23] + 23'(round_up);
    assign e_rnd = s1_q.exp + $signed({10'b0, carry});

    always_comb begin
        res_d = {s1_q.sign, 31'b0};
        of_d  = 1'b0;
        uf_d  = 1'b0;
        nx_d  = 1'b0;
        if (s1_q.zero) begin
            res_d = {s1_q.sign, 31'b0};
        end else if (e_rnd >= $signed(11'(2 * C_EXP_BIAS + 1))) begin
            of_d  = 1'b1;
            nx_d  = 1'b1;
            res_d = to_inf ? {s1_q.sign, C_EXP_INF, 23'b0} : {s1_q.sign, C_MAX_FINITE};
        end else if (e_rnd <= 11'sd0) begin
            uf_d  = 1'b1;
            nx_d  = 1'b1;
            res_d = {s1_q.sign, 31'b0};
        end else begin
            nx_d  = inexact;
            res_d = {s1_q.sign, e_rnd[C_EXP-1:0], frac};
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            s1_q  <= '0;
            res_q <= '0;
            of_q  <= 1'b0;
            uf_q  <= 1'b0;
            nx_q  <= 1'b0;
        end else begin
            if (Flush_SI) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else begin
                if (s1_ready) v1_q <= In_valid_SI;
                if (s2_ready) v2_q <= v1_q;
            end
            if (s1_load) s1_q <= s1_d;
            if (s2_load) begin
                res_q <= res_d;
                of_q  <= of_d;
                uf_q  <= uf_d;
                nx_q  <= nx_d;
            end
        end
    end

    assign Out_valid_SO = v2_q;
    assign Result_DO    = res_q;
    assign OF_SO        = of_q;
    assign UF_SO        = uf_q;
    assign NX_SO        = nx_q;

endmodule
